// File: rtl/cache_valid_array_flush.sv
// Purpose: SETS x WAYS valid-bit array with single-bit fill/invalidate,
//          a registered lookup port and a one-set-per-cycle flush sweep.
// Latency: lookup response 1 cycle after acceptance; flush takes SETS cycles.
// Backpressure: the response is held until rsp_ready. Lookups, fills and
//               invalidates stall while the sweep runs.
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   lookup_valid/ready, lookup_index    lookup request handshake
//   rsp_valid/ready, rsp_rdata          lookup response (bit w = way w)
//   fill_valid, fill_index, fill_way    set one valid bit
//   inval_valid, inval_index, inval_way clear one valid bit
//   wr_ready                            fill/invalidate accepted (= !flush_busy)
//   flush_req, flush_busy, flush_done   whole-array clear control/status
module cache_valid_array_flush #(
  parameter int WAYS = 8,
  parameter int SETS = 64,
  localparam int WAY_W = $clog2(WAYS),
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lookup_valid,
  input  logic [IDX_W-1:0] lookup_index,
  output logic             lookup_ready,
  output logic             rsp_valid,
  output logic [WAYS-1:0]  rsp_rdata,
  input  logic             rsp_ready,
  input  logic             fill_valid,
  input  logic [IDX_W-1:0] fill_index,
  input  logic [WAY_W-1:0] fill_way,
  input  logic             inval_valid,
  input  logic [IDX_W-1:0] inval_index,
  input  logic [WAY_W-1:0] inval_way,
  output logic             wr_ready,
  input  logic             flush_req,
  output logic             flush_busy,
  output logic             flush_done
);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q;
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   valid_d [SETS];
  logic              sweep_clr;
  logic              last_set;
  logic              fill_acc;
  logic              inval_acc;
  logic              lookup_acc;

  // ---------------- flush FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign last_set = (cnt_q == IDX_W'(SETS - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flush_req) state_d = SWEEP;
      SWEEP:   if (last_set)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // flush_done is high during the cycle that clears the final set, so an
  // aborted sweep (reset) never produces it.
  always_comb begin
    flush_busy = 1'b0;
    flush_done = 1'b0;
    sweep_clr  = 1'b0;
    if (state_q == SWEEP) begin
      flush_busy = 1'b1;
      sweep_clr  = 1'b1;
      flush_done = last_set;
    end
  end

  // Sweep counter: zeroed on entry, wraps to 0 naturally after SETS-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      if (flush_req) cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // ---------------- valid array ----------------
  assign wr_ready  = !flush_busy;
  assign fill_acc  = fill_valid  && wr_ready;
  assign inval_acc = inval_valid && wr_ready;

  // Invalidate is applied after fill so a same-bit collision ends cleared.
  // Sweep and writes never coincide because wr_ready is low while sweeping.
  always_comb begin
    for (int s = 0; s < SETS; s++) valid_d[s] = valid_q[s];
    if (fill_acc)  valid_d[fill_index][fill_way]   = 1'b1;
    if (inval_acc) valid_d[inval_index][inval_way] = 1'b0;
    if (sweep_clr) valid_d[cnt_q] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else begin
      for (int s = 0; s < SETS; s++) valid_q[s] <= valid_d[s];
    end
  end

  // ---------------- lookup / response ----------------
  assign lookup_ready = !flush_busy && (!rsp_valid || rsp_ready);
  assign lookup_acc   = lookup_valid && lookup_ready;

  // Reads valid_q (pre-edge contents), giving read-before-write ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else if (lookup_acc) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= valid_q[lookup_index];
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_valid_array_flush.sv
module tb_cache_valid_array_flush;

  localparam int WAYS  = 8;
  localparam int SETS  = 64;
  localparam int WAY_W = 3;
  localparam int IDX_W = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             lookup_valid;
  logic [IDX_W-1:0] lookup_index;
  logic             lookup_ready;
  logic             rsp_valid;
  logic [WAYS-1:0]  rsp_rdata;
  logic             rsp_ready;
  logic             fill_valid;
  logic [IDX_W-1:0] fill_index;
  logic [WAY_W-1:0] fill_way;
  logic             inval_valid;
  logic [IDX_W-1:0] inval_index;
  logic [WAY_W-1:0] inval_way;
  logic             wr_ready;
  logic             flush_req;
  logic             flush_busy;
  logic             flush_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cache_valid_array_flush #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid(lookup_valid), .lookup_index(lookup_index), .lookup_ready(lookup_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_ready(rsp_ready),
    .fill_valid(fill_valid), .fill_index(fill_index), .fill_way(fill_way),
    .inval_valid(inval_valid), .inval_index(inval_index), .inval_way(inval_way),
    .wr_ready(wr_ready),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fill(input int idx, input int way);
    fill_valid = 1'b1; fill_index = IDX_W'(idx); fill_way = WAY_W'(way);
    tick();
    fill_valid = 1'b0;
  endtask

  // Lookup with rsp_ready high; response checked one cycle after acceptance.
  task automatic do_lookup(input string tag, input int idx, input logic [7:0] exp);
    lookup_valid = 1'b1; lookup_index = IDX_W'(idx);
    tick();
    lookup_valid = 1'b0;
    chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_dat"}, 32'(rsp_rdata), 32'(exp));
    tick();
  endtask

  initial begin
    int busy_cnt, done_cnt, done_at, bad, dones_after;
    bit  req2_sent;

    rst_n = 1'b0;
    lookup_valid = 0; lookup_index = '0; rsp_ready = 1'b1;
    fill_valid = 0; fill_index = '0; fill_way = '0;
    inval_valid = 0; inval_index = '0; inval_way = '0;
    flush_req = 0;

    // Reset state
    #12;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    chk("rst_busy",      32'(flush_busy), 0);
    chk("rst_done",      32'(flush_done), 0);
    rst_n = 1'b1;
    tick();
    chk("rst_lookup_ready", 32'(lookup_ready), 1);
    chk("rst_wr_ready",     32'(wr_ready), 1);

    // Single fill then lookup
    do_fill(5, 3);
    do_lookup("fill5w3", 5, 8'h08);

    // Read-before-write: lookup and invalidate in the same cycle
    do_fill(7, 0);
    do_fill(7, 7);
    lookup_valid = 1; lookup_index = 7;
    inval_valid = 1; inval_index = 7; inval_way = 0;
    tick();
    lookup_valid = 0; inval_valid = 0;
    chk("rbw_dat", 32'(rsp_rdata), 32'h81);
    tick();
    do_lookup("after_inval7", 7, 8'h80);

    // Same-bit fill+invalidate collision leaves it cleared
    fill_valid = 1; fill_index = 2; fill_way = 4;
    inval_valid = 1; inval_index = 2; inval_way = 4;
    tick();
    fill_valid = 0; inval_valid = 0;
    do_lookup("collide2w4", 2, 8'h00);

    // Different sets in the same cycle both apply
    fill_valid = 1; fill_index = 3; fill_way = 1;
    inval_valid = 1; inval_index = 7; inval_way = 7;
    tick();
    fill_valid = 0; inval_valid = 0;
    do_lookup("both_fill3", 3, 8'h02);
    do_lookup("both_inval7", 7, 8'h00);

    // Response backpressure
    rsp_ready = 0;
    lookup_valid = 1; lookup_index = 5;
    tick();
    lookup_valid = 0;
    fill_valid = 1; fill_index = 5; fill_way = 0;  // array changes, response must not
    for (int i = 0; i < 5; i++) begin
      chk("hold_vld", 32'(rsp_valid), 1);
      chk("hold_dat", 32'(rsp_rdata), 32'h08);
      chk("hold_lrdy", 32'(lookup_ready), 0);
      tick();
      fill_valid = 0;
    end
    rsp_ready = 1;
    #1;
    chk("release_lrdy", 32'(lookup_ready), 1);
    tick();
    chk("drain_vld", 32'(rsp_valid), 0);
    chk("drain_keep_dat", 32'(rsp_rdata), 32'h08);
    do_lookup("fill5w0", 5, 8'h09);

    // Flush with a pending response and a fill in the flush_req cycle
    do_fill(0, 2);
    do_fill(63, 1);
    rsp_ready = 0;
    lookup_valid = 1; lookup_index = 63;
    tick();
    lookup_valid = 0;
    flush_req = 1;
    fill_valid = 1; fill_index = 10; fill_way = 5;
    tick();
    flush_req = 0; fill_valid = 0;
    busy_cnt = 0; done_cnt = 0; done_at = -1; bad = 0; req2_sent = 0;
    for (int c = 0; c < 100; c++) begin
      flush_req = 0;
      lookup_valid = 0;
      if (flush_busy) busy_cnt++;
      if (flush_done) begin done_cnt++; done_at = busy_cnt; end
      if (flush_busy && (wr_ready || lookup_ready)) bad++;
      if (busy_cnt == 5 && flush_busy) begin
        chk("flush_pend_vld", 32'(rsp_valid), 1);
        chk("flush_pend_dat", 32'(rsp_rdata), 32'h02);
      end
      if (busy_cnt == 20 && !req2_sent) begin
        flush_req = 1; req2_sent = 1;
      end
      if (busy_cnt == 30) begin
        rsp_ready = 1;
        lookup_valid = 1; lookup_index = 63;  // must not be accepted while busy
      end
      tick();
    end
    flush_req = 0; lookup_valid = 0;
    chk("flush_busy_cycles", 32'(busy_cnt), 64);
    chk("flush_done_count", 32'(done_cnt), 1);
    chk("flush_done_at", 32'(done_at), 64);
    chk("flush_ready_low", 32'(bad), 0);
    chk("flush_rsp_drained", 32'(rsp_valid), 0);
    chk("flush_idle_busy", 32'(flush_busy), 0);
    do_lookup("flushed0", 0, 8'h00);
    do_lookup("flushed63", 63, 8'h00);
    do_lookup("flushed10", 10, 8'h00);

    // Reset in the middle of a sweep
    do_fill(4, 6);
    do_fill(50, 0);
    flush_req = 1;
    tick();
    flush_req = 0;
    dones_after = 0;
    for (int c = 0; c < 10; c++) begin
      if (flush_done) dones_after++;
      tick();
    end
    chk("sweep_busy_c10", 32'(flush_busy), 1);
    rst_n = 0;
    #1;
    chk("abort_busy", 32'(flush_busy), 0);
    chk("abort_done", 32'(flush_done), 0);
    tick();
    rst_n = 1;
    for (int c = 0; c < 70; c++) begin
      if (flush_done || flush_busy) dones_after++;
      tick();
    end
    chk("abort_no_done", 32'(dones_after), 0);
    do_lookup("abort4", 4, 8'h00);
    do_lookup("abort50", 50, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
